// File: rtl/pipe_hazard_unit_if.sv
// rtl/pipe_hazard_unit_if.sv - pipeline-side bundle for the hazard/forward/stall controller
interface pipe_hazard_unit_if #(
  parameter int NUM_MCU = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
);
  logic [REG_AW-1:0]  exe_rs1_addr;
  logic [REG_AW-1:0]  exe_rs2_addr;
  logic               exe_use_rs1;
  logic               exe_use_rs2;
  logic               exe_new_pc_req;
  logic [REG_AW-1:0]  mem_rd_addr;
  logic               mem_rd_wr_req;
  logic [REG_AW-1:0]  wrb_rd_addr;
  logic               wrb_rd_wr_req;
  logic [NUM_MCU-1:0] mcu_req;
  logic [NUM_MCU-1:0] mcu_ack;
  logic               csr_read_req;
  logic               csr_new_pc_req;
  logic               csr_wfi_req;
  logic               csr_irq_flush_lsu;
  logic               timeout_clr;
  logic               cnt_clr;

  logic               fwd_mem_rs1;
  logic               fwd_mem_rs2;
  logic               fwd_wrb_rs1;
  logic               fwd_wrb_rs2;
  logic               if2id_stall;
  logic               id2exe_stall;
  logic               exe2mem_stall;
  logic               if2id_flush;
  logic               id2exe_flush;
  logic               exe2mem_flush;
  logic               mem2wrb_flush;
  logic               mem_flush;
  logic               if_exe_new_pc;
  logic               if_csr_new_pc;
  logic               if_wfi;
  logic               if_stall;
  logic               csr_pipe_stall;
  logic [NUM_MCU-1:0] mcu_busy;
  logic [NUM_MCU-1:0] mcu_timeout;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   hazard_cnt;

  modport master (
    output exe_rs1_addr, exe_rs2_addr, exe_use_rs1, exe_use_rs2, exe_new_pc_req,
           mem_rd_addr, mem_rd_wr_req, wrb_rd_addr, wrb_rd_wr_req, mcu_req, mcu_ack,
           csr_read_req, csr_new_pc_req, csr_wfi_req, csr_irq_flush_lsu, timeout_clr, cnt_clr,
    input  fwd_mem_rs1, fwd_mem_rs2, fwd_wrb_rs1, fwd_wrb_rs2, if2id_stall, id2exe_stall,
           exe2mem_stall, if2id_flush, id2exe_flush, exe2mem_flush, mem2wrb_flush, mem_flush,
           if_exe_new_pc, if_csr_new_pc, if_wfi, if_stall, csr_pipe_stall, mcu_busy,
           mcu_timeout, stall_cnt, hazard_cnt
  );

  modport slave (
    input  exe_rs1_addr, exe_rs2_addr, exe_use_rs1, exe_use_rs2, exe_new_pc_req,
           mem_rd_addr, mem_rd_wr_req, wrb_rd_addr, wrb_rd_wr_req, mcu_req, mcu_ack,
           csr_read_req, csr_new_pc_req, csr_wfi_req, csr_irq_flush_lsu, timeout_clr, cnt_clr,
    output fwd_mem_rs1, fwd_mem_rs2, fwd_wrb_rs1, fwd_wrb_rs2, if2id_stall, id2exe_stall,
           exe2mem_stall, if2id_flush, id2exe_flush, exe2mem_flush, mem2wrb_flush, mem_flush,
           if_exe_new_pc, if_csr_new_pc, if_wfi, if_stall, csr_pipe_stall, mcu_busy,
           mcu_timeout, stall_cnt, hazard_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - forwarding, stall/flush control and multi-cycle unit tracking for the 5-stage pipe
module pipe_hazard_unit #(
  parameter int NUM_MCU     = 2,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_unit_if.slave bus
);
  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit              WD_EN   = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [REG_AW-1:0]  rs1_addr, rs2_addr;
  logic               rs1_valid, rs2_valid;
  logic               mem_hit1, mem_hit2, wrb_hit1, wrb_hit2;
  logic               fwd_mem1, fwd_mem2;
  logic               long_lat, mcu_stall, ld_use, pipe_stall, exe_pc_ok, mem_flush;
  logic [NUM_MCU-1:0] busy_ff, busy_next, busy_cyc, wd_hit, timeout_ff;
  logic [WD_W-1:0]    wd_cnt [NUM_MCU];
  logic [CNT_W-1:0]   stall_cnt_ff, hazard_cnt_ff;
  logic               stall_d;

  assign rs1_addr  = bus.exe_rs1_addr;
  assign rs2_addr  = bus.exe_rs2_addr;
  assign rs1_valid = |rs1_addr;
  assign rs2_valid = |rs2_addr;
  assign mem_hit1  = (rs1_addr == bus.mem_rd_addr) & bus.mem_rd_wr_req & rs1_valid;
  assign mem_hit2  = (rs2_addr == bus.mem_rd_addr) & bus.mem_rd_wr_req & rs2_valid;
  assign wrb_hit1  = (rs1_addr == bus.wrb_rd_addr) & bus.wrb_rd_wr_req & rs1_valid;
  assign wrb_hit2  = (rs2_addr == bus.wrb_rd_addr) & bus.wrb_rd_wr_req & rs2_valid;

  // A MEM-stage result is only forwardable when it is produced in a single cycle
  assign long_lat  = (|bus.mcu_req) | bus.csr_read_req;
  assign fwd_mem1  = mem_hit1 & ~long_lat;
  assign fwd_mem2  = mem_hit2 & ~long_lat;

  // Ack beats req, so a same-cycle req/ack pair never shows up as busy
  assign busy_next  = (busy_ff | bus.mcu_req) & ~bus.mcu_ack;
  assign busy_cyc   = busy_ff & ~bus.mcu_ack;
  assign mcu_stall  = |busy_next;
  assign ld_use     = ((mem_hit1 & bus.exe_use_rs1) | (mem_hit2 & bus.exe_use_rs2))
                      & long_lat & ~mcu_stall;
  assign pipe_stall = ld_use | mcu_stall;
  assign exe_pc_ok  = bus.exe_new_pc_req & ~pipe_stall;
  assign mem_flush  = bus.csr_new_pc_req | bus.csr_wfi_req;

  assign bus.fwd_mem_rs1    = fwd_mem1;
  assign bus.fwd_mem_rs2    = fwd_mem2;
  assign bus.fwd_wrb_rs1    = wrb_hit1 & ~fwd_mem1;
  assign bus.fwd_wrb_rs2    = wrb_hit2 & ~fwd_mem2;
  assign bus.if_stall       = pipe_stall;
  assign bus.if2id_stall    = pipe_stall;
  assign bus.id2exe_stall   = pipe_stall;
  assign bus.exe2mem_stall  = mcu_stall;
  assign bus.if2id_flush    = exe_pc_ok | mem_flush;
  assign bus.id2exe_flush   = exe_pc_ok | mem_flush;
  assign bus.exe2mem_flush  = ld_use | mem_flush;
  assign bus.mem2wrb_flush  = bus.csr_irq_flush_lsu;
  assign bus.mem_flush      = mem_flush;
  assign bus.if_exe_new_pc  = exe_pc_ok & ~bus.csr_new_pc_req;
  assign bus.if_csr_new_pc  = bus.csr_new_pc_req;
  assign bus.if_wfi         = bus.csr_wfi_req;
  assign bus.csr_pipe_stall = stall_d;
  assign bus.mcu_busy       = busy_ff;
  assign bus.mcu_timeout    = timeout_ff;
  assign bus.stall_cnt      = stall_cnt_ff;
  assign bus.hazard_cnt     = hazard_cnt_ff;

  always_comb begin
    wd_hit = '0;
    for (int i = 0; i < NUM_MCU; i++) begin
      wd_hit[i] = WD_EN & busy_cyc[i] & (wd_cnt[i] == WD_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_ff    <= '0;
      timeout_ff <= '0;
      for (int i = 0; i < NUM_MCU; i++) begin
        wd_cnt[i] <= '0;
      end
    end else begin
      busy_ff <= busy_next & ~wd_hit & {NUM_MCU{~mem_flush}};
      // A timeout landing together with the clear must survive
      timeout_ff <= (bus.timeout_clr ? '0 : timeout_ff) | wd_hit;
      for (int i = 0; i < NUM_MCU; i++) begin
        if (!WD_EN || !busy_cyc[i] || wd_hit[i]) begin
          wd_cnt[i] <= '0;
        end else begin
          wd_cnt[i] <= wd_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_d       <= 1'b0;
      stall_cnt_ff  <= '0;
      hazard_cnt_ff <= '0;
    end else begin
      stall_d <= pipe_stall;
      if (bus.cnt_clr) begin
        stall_cnt_ff  <= '0;
        hazard_cnt_ff <= '0;
      end else begin
        if (pipe_stall && (stall_cnt_ff != '1)) begin
          stall_cnt_ff <= stall_cnt_ff + 1'b1;
        end
        if (ld_use && (hazard_cnt_ff != '1)) begin
          hazard_cnt_ff <= hazard_cnt_ff + 1'b1;
        end
      end
    end
  end
endmodule
